user_io_mux: RTL and testbench

USER_IO_MUX -- requirements
Module: user_io_mux

---
 rtl/user_io_mux.sv | 188 ++++++++++++++++++
 tb/tb_user_io_mux.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/user_io_mux.sv
// user_io_mux: Wishbone-configurable routing between user I/O pads and core
// signal channels.
//   Each pad has a PADCFG word. Its mode field selects one of four behaviours:
//   off, drive from a core channel, feed a core channel, or GPIO output.
//   A CTRL word holds a global output enable and a read-only hold_done flag.
//   No pad may drive until HOLD cycles have elapsed after reset release.
// Ports:
//   wb_clk_i, ext_rst          clock, asynchronous active-low reset
//   wbs_*                      Wishbone slave (word index = wbs_adr_i[7:2])
//   core_out / core_in         core-to-pad / pad-to-core channels (NCORE each)
//   io_in / io_out / io_oeb    pad input, output value, active-low output enable
// Build option:
//   USER_IO_MUX_SYNC_EN        when defined, io_in passes a 2-flop synchronizer
module user_io_mux #(
   parameter int unsigned NPADS = 38,
   parameter int unsigned NCORE = 16,
   parameter int unsigned HOLD  = 16
) (
   input  logic              wb_clk_i,
   input  logic              ext_rst,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic [NCORE-1:0]  core_out,
   output logic [NCORE-1:0]  core_in,
   input  logic [NPADS-1:0]  io_in,
   output logic [NPADS-1:0]  io_out,
   output logic [NPADS-1:0]  io_oeb
);

   localparam int unsigned SW       = $clog2(NCORE);
   localparam int unsigned CW       = $clog2(HOLD + 1);
   localparam logic [5:0]  CTRL_IDX = 6'd63;

   logic [1:0]       mode_q [NPADS];
   logic [1:0]       mode_d [NPADS];
   logic [SW-1:0]    sel_q  [NPADS];
   logic [SW-1:0]    sel_d  [NPADS];
   logic [NPADS-1:0] gpo_q, gpo_d;
   logic             oe_global_q, oe_global_d;
   logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;

   logic [NPADS-1:0] pin_s;
   logic [5:0]       idx;
   logic             req, pad_hit, ctrl_hit, hold_done, drive_ok;
   logic [31:0]      wmask, cur_word, wr_word;
   logic             unused_ok;

   // Pad input sample seen by core_in and PADCFG bit 24
`ifdef USER_IO_MUX_SYNC_EN
   logic [NPADS-1:0] sync1_q, sync2_q;

   always_ff @(posedge wb_clk_i or negedge ext_rst) begin
      if (!ext_rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= io_in;
         sync2_q <= sync1_q;
      end
   end

   assign pin_s = sync2_q;
`else
   assign pin_s = io_in;
`endif

   assign idx       = wbs_adr_i[7:2];
   assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign pad_hit   = (idx < 6'(NPADS));
   assign ctrl_hit  = (idx == CTRL_IDX);
   assign hold_done = (hold_cnt_q == CW'(HOLD));
   assign drive_ok  = hold_done & oe_global_q;
   assign wmask     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                       {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign unused_ok = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], wr_word};

   // Current PADCFG word at the addressed index, used for reads and byte merges
   always_comb begin
      cur_word = '0;
      for (int i = 0; i < int'(NPADS); i++) begin
         if (idx == 6'(i)) begin
            cur_word[1:0]     = mode_q[i];
            cur_word[4 +: SW] = sel_q[i];
            cur_word[16]      = gpo_q[i];
            cur_word[24]      = pin_s[i];
         end
      end
   end

   assign wr_word = (cur_word & ~wmask) | (wbs_dat_i & wmask);

   // Next-state: register writes, read data, ack and hold counter
   always_comb begin
      mode_d      = mode_q;
      sel_d       = sel_q;
      gpo_d       = gpo_q;
      oe_global_d = oe_global_q;
      hold_cnt_d  = hold_done ? hold_cnt_q : hold_cnt_q + CW'(1);
      ack_d       = req;
      dat_d       = '0;
      if (req && !wbs_we_i) begin
         if (pad_hit) begin
            dat_d = cur_word;
         end else if (ctrl_hit) begin
            dat_d = {30'd0, hold_done, oe_global_q};
         end
      end
      if (req && wbs_we_i) begin
         for (int i = 0; i < int'(NPADS); i++) begin
            if (idx == 6'(i)) begin
               mode_d[i] = wr_word[1:0];
               sel_d[i]  = wr_word[4 +: SW];
               gpo_d[i]  = wr_word[16];
            end
         end
         if (ctrl_hit && wbs_sel_i[0]) begin
            oe_global_d = wbs_dat_i[0];
         end
      end
   end

   // State registers
   always_ff @(posedge wb_clk_i or negedge ext_rst) begin
      if (!ext_rst) begin
         for (int i = 0; i < int'(NPADS); i++) begin
            mode_q[i] <= '0;
            sel_q[i]  <= '0;
         end
         gpo_q       <= '0;
         oe_global_q <= 1'b1;
         hold_cnt_q  <= '0;
         ack_q       <= 1'b0;
         dat_q       <= '0;
      end else begin
         mode_q      <= mode_d;
         sel_q       <= sel_d;
         gpo_q       <= gpo_d;
         oe_global_q <= oe_global_d;
         hold_cnt_q  <= hold_cnt_d;
         ack_q       <= ack_d;
         dat_q       <= dat_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;

   // Pad drive: nothing drives or toggles until the hold window has elapsed
   always_comb begin
      io_out = '0;
      io_oeb = '1;
      for (int i = 0; i < int'(NPADS); i++) begin
         case (mode_q[i])
            2'd1: begin
               io_out[i] = hold_done & core_out[sel_q[i]];
               io_oeb[i] = ~drive_ok;
            end
            2'd3: begin
               io_out[i] = hold_done & gpo_q[i];
               io_oeb[i] = ~drive_ok;
            end
            default: begin
               io_out[i] = 1'b0;
               io_oeb[i] = 1'b1;
            end
         endcase
      end
   end

   // Pad-to-core routing; scanning downward lets the lowest pad index win
   always_comb begin
      core_in = '0;
      for (int i = int'(NPADS) - 1; i >= 0; i--) begin
         if (hold_done && (mode_q[i] == 2'd2)) begin
            core_in[sel_q[i]] = pin_s[i];
         end
      end
   end

endmodule

// File: tb/tb_user_io_mux.sv
// Bench for user_io_mux (default build): Wishbone reads are scored against a
// queue of expected responses; pad and core routing is checked directly.
module tb_user_io_mux;

   localparam int unsigned NPADS = 38;
   localparam int unsigned NCORE = 16;
   localparam int unsigned HOLD  = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             stb, cyc, we;
   logic [3:0]       sel;
   logic [31:0]      adr, dat_w;
   logic             ack;
   logic [31:0]      dat_r;
   logic [NCORE-1:0] core_out, core_in;
   logic [NPADS-1:0] io_in, io_out, io_oeb;
   logic [NPADS-1:0] all1;

   typedef struct {
      logic        is_read;
      logic [31:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  checks = 0;
   int  errors = 0;
   int  edge_n = 0;

   always #5 clk = ~clk;

   user_io_mux #(.NPADS(NPADS), .NCORE(NCORE), .HOLD(HOLD)) dut (
      .wb_clk_i (clk),
      .ext_rst  (rst_n),
      .wbs_stb_i(stb),
      .wbs_cyc_i(cyc),
      .wbs_we_i (we),
      .wbs_sel_i(sel),
      .wbs_adr_i(adr),
      .wbs_dat_i(dat_w),
      .wbs_ack_o(ack),
      .wbs_dat_o(dat_r),
      .core_out (core_out),
      .core_in  (core_in),
      .io_in    (io_in),
      .io_out   (io_out),
      .io_oeb   (io_oeb)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   // One Wishbone transaction; read data is checked by the scoreboard monitor
   task automatic wb_xfer(input logic w, input logic [5:0] idx, input logic [3:0] s,
                          input logic [31:0] d, input logic [31:0] exp);
      sb_t e;
      logic got;
      e.is_read = ~w;
      e.exp     = exp;
      sb_q.push_back(e);
      cyc   = 1'b1;
      stb   = 1'b1;
      we    = w;
      sel   = s;
      adr   = {24'h00A5C3, idx, 2'b11};
      dat_w = d;
      got   = 1'b0;
      for (int n = 0; n < 8 && !got; n++) begin
         tick();
         if (ack) got = 1'b1;
      end
      cyc = 1'b0;
      stb = 1'b0;
      we  = 1'b0;
      check_eq("ack_seen", 64'(got), 64'd1);
      if (!got && sb_q.size() != 0) void'(sb_q.pop_back());
      tick();
      check_eq("ack_single", 64'(ack), 64'd0);
      check_eq("dat_idle", 64'(dat_r), 64'd0);
   endtask

   // Scoreboard monitor: every ack consumes one expected response
   always @(negedge clk) begin
      if (rst_n && ack) begin
         check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            sb_t e;
            e = sb_q.pop_front();
            if (e.is_read) check_eq("rd_data", 64'(dat_r), 64'(e.exp));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      all1     = '1;
      rst_n    = 1'b0;
      stb      = 1'b0;
      cyc      = 1'b0;
      we       = 1'b0;
      sel      = 4'h0;
      adr      = '0;
      dat_w    = '0;
      core_out = '0;
      io_in    = '0;

      // Reset state
      repeat (3) tick();
      check_eq("rst_oeb", 64'(io_oeb), 64'(all1));
      check_eq("rst_out", 64'(io_out), 64'd0);
      check_eq("rst_core_in", 64'(core_in), 64'd0);
      check_eq("rst_ack", 64'(ack), 64'd0);
      check_eq("rst_dat", 64'(dat_r), 64'd0);

      // Hold window: CTRL=1 early, write accepted but pad held off until HOLD
      @(negedge clk);
      rst_n  = 1'b1;
      edge_n = 0;
      wb_xfer(1'b0, 6'd63, 4'hF, 32'h0, 32'h1);
      wb_xfer(1'b1, 6'd6, 4'hF, 32'h0000_0031, 32'h0);
      core_out[3] = 1'b1;
      while (edge_n < int'(HOLD)) begin
         check_eq("hold_oeb", 64'(io_oeb), 64'(all1));
         check_eq("hold_out", 64'(io_out), 64'd0);
         tick();
      end
      check_eq("pad6_oeb_after_hold", 64'(io_oeb[6]), 64'd0);
      check_eq("pad6_out_after_hold", 64'(io_out[6]), 64'd1);
      wb_xfer(1'b0, 6'd63, 4'hF, 32'h0, 32'h3);
      core_out[3] = 1'b0;
      #1;
      check_eq("pad6_follow_core", 64'(io_out[6]), 64'd0);
      core_out[3] = 1'b1;
      wb_xfer(1'b1, 6'd63, 4'hF, 32'h0, 32'h0);
      check_eq("pad6_oe_global_off", 64'(io_oeb[6]), 64'd1);
      wb_xfer(1'b1, 6'd63, 4'hF, 32'h1, 32'h0);
      check_eq("pad6_oe_global_on", 64'(io_oeb[6]), 64'd0);

      // Last pad driven from the last core channel
      wb_xfer(1'b1, 6'd37, 4'hF, 32'h0000_00F1, 32'h0);
      core_out[15] = 1'b1;
      #1;
      check_eq("pad37_hi", 64'(io_out[37]), 64'd1);
      core_out[15] = 1'b0;
      #1;
      check_eq("pad37_lo", 64'(io_out[37]), 64'd0);

      // Two mode-2 pads on one channel: lowest index wins
      io_in[20] = 1'b1;
      wb_xfer(1'b1, 6'd5, 4'hF, 32'h0000_0022, 32'h0);
      wb_xfer(1'b1, 6'd20, 4'hF, 32'h0000_0022, 32'h0);
      check_eq("core_in_pad5_wins", 64'(core_in), 64'd0);
      io_in[5] = 1'b1;
      #1;
      check_eq("core_in_pad5_hi", 64'(core_in), 64'h4);
      io_in[5] = 1'b0;
      wb_xfer(1'b1, 6'd5, 4'hF, 32'h0, 32'h0);
      check_eq("core_in_pad20", 64'(core_in), 64'h4);
      wb_xfer(1'b0, 6'd20, 4'hF, 32'h0, 32'h0100_0022);
      io_in[20] = 1'b0;
      #1;
      check_eq("core_in_pad20_lo", 64'(core_in), 64'd0);

      // Byte-lane masking on PADCFG[9]
      wb_xfer(1'b1, 6'd9, 4'h1, 32'h0001_0003, 32'h0);
      wb_xfer(1'b0, 6'd9, 4'hF, 32'h0, 32'h0000_0003);
      check_eq("pad9_gpo_masked", 64'(io_out[9]), 64'd0);
      wb_xfer(1'b1, 6'd9, 4'h4, 32'h0001_0003, 32'h0);
      wb_xfer(1'b0, 6'd9, 4'hF, 32'h0, 32'h0001_0003);
      check_eq("pad9_gpo_out", 64'(io_out[9]), 64'd1);
      check_eq("pad9_gpo_oeb", 64'(io_oeb[9]), 64'd0);

      // Unmapped indices read 0 and ignore writes; CTRL with no lanes ignored
      wb_xfer(1'b0, 6'd50, 4'hF, 32'h0, 32'h0);
      wb_xfer(1'b1, 6'd50, 4'hF, 32'hFFFF_FFFF, 32'h0);
      wb_xfer(1'b0, 6'd62, 4'hF, 32'h0, 32'h0);
      wb_xfer(1'b0, 6'd9, 4'hF, 32'h0, 32'h0001_0003);
      wb_xfer(1'b1, 6'd63, 4'h0, 32'h0, 32'h0);
      check_eq("ctrl_sel0_ignored", 64'(io_oeb[9]), 64'd0);

      // Reset during a pending write aborts it and restarts the hold window
      cyc   = 1'b1;
      stb   = 1'b1;
      we    = 1'b1;
      sel   = 4'hF;
      adr   = 32'h0;
      dat_w = 32'h0001_0003;
      #3;
      rst_n = 1'b0;
      #1;
      cyc = 1'b0;
      stb = 1'b0;
      we  = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         check_eq("abort_no_ack", 64'(ack), 64'd0);
      end
      check_eq("abort_oeb", 64'(io_oeb), 64'(all1));
      @(negedge clk);
      rst_n  = 1'b1;
      edge_n = 0;
      wb_xfer(1'b0, 6'd0, 4'hF, 32'h0, 32'h0);
      wb_xfer(1'b0, 6'd63, 4'hF, 32'h0, 32'h1);
      check_eq("abort_oeb_after", 64'(io_oeb), 64'(all1));
      repeat (2) tick();
      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
